decode_pipe_stage: RTL and testbench

DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

---
 rtl/decode_pipe_stage_pkg.sv | 104 ++++++++++
 rtl/decode_pipe_stage_if.sv | 43 ++++
 rtl/decode_pipe_stage_regfile.sv | 73 +++++++
 rtl/decode_pipe_stage.sv | 163 ++++++++++++++++
 tb/tb_decode_pipe_stage.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pipe_stage_pkg.sv
// Shared decode definitions: opcodes, ALUOp encodings, ex_ctrl layout and the
// opcode-to-control lookup used by the decode stage.
package decode_pipe_stage_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_FUNCT  = 2'b10
    } aluop_e;

    // Bit positions inside the 8-bit ex_ctrl bundle
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_ALUOP_LO = 6;

    typedef struct packed {
        aluop_e alu_op;
        logic   alu_src;
        logic   branch;
        logic   mem_read;
        logic   mem_to_reg;
        logic   mem_write;
        logic   reg_write;
    } ctrl_t;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2,
        IMM_B    = 2'd3
    } imm_sel_e;

    typedef struct packed {
        ctrl_t    ctrl;
        imm_sel_e imm_sel;
        logic     use_rs1;
        logic     use_rs2;
        logic     legal;
    } dec_t;

    function automatic dec_t decode_op(input logic [6:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_R: begin
                d.ctrl.alu_op    = ALUOP_FUNCT;
                d.ctrl.reg_write = 1'b1;
                d.use_rs1        = 1'b1;
                d.use_rs2        = 1'b1;
                d.legal          = 1'b1;
            end
            OP_I: begin
                d.ctrl.alu_op    = ALUOP_FUNCT;
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.imm_sel        = IMM_I;
                d.use_rs1        = 1'b1;
                d.legal          = 1'b1;
            end
            OP_LOAD: begin
                d.ctrl.alu_op     = ALUOP_ADD;
                d.ctrl.alu_src    = 1'b1;
                d.ctrl.mem_read   = 1'b1;
                d.ctrl.mem_to_reg = 1'b1;
                d.ctrl.reg_write  = 1'b1;
                d.imm_sel         = IMM_I;
                d.use_rs1         = 1'b1;
                d.legal           = 1'b1;
            end
            OP_STORE: begin
                d.ctrl.alu_op    = ALUOP_ADD;
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.mem_write = 1'b1;
                d.imm_sel        = IMM_S;
                d.use_rs1        = 1'b1;
                d.use_rs2        = 1'b1;
                d.legal          = 1'b1;
            end
            OP_BRANCH: begin
                d.ctrl.alu_op = ALUOP_BRANCH;
                d.ctrl.branch = 1'b1;
                d.imm_sel     = IMM_B;
                d.use_rs1     = 1'b1;
                d.use_rs2     = 1'b1;
                d.legal       = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_pipe_stage_if.sv
// Fetch, writeback and ID/EX bundle signals of the decode stage.
// slave = the decode stage itself, master = its environment.
interface decode_pipe_stage_if
    import decode_pipe_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;
    logic            ex_ready;
    logic            flush;
    logic            wb_regWrite;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_writeData;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_readData1;
    logic [XLEN-1:0] ex_readData2;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rd;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [2:0]      ex_funct3;
    logic            ex_i30;
    logic [7:0]      ex_ctrl;
    logic            ex_illegal;

    modport slave (
        input  if_valid, if_instr, if_pc, ex_ready, flush,
               wb_regWrite, wb_rd, wb_writeData,
        output id_ready, ex_valid, ex_pc, ex_readData1, ex_readData2, ex_imm,
               ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_i30, ex_ctrl, ex_illegal
    );

    modport master (
        output if_valid, if_instr, if_pc, ex_ready, flush,
               wb_regWrite, wb_rd, wb_writeData,
        input  id_ready, ex_valid, ex_pc, ex_readData1, ex_readData2, ex_imm,
               ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_i30, ex_ctrl, ex_illegal
    );
endinterface

// File: rtl/decode_pipe_stage_regfile.sv
// Architectural register file: two async read ports, one write port,
// x0 hard-wired to zero, optional write-first bypass.
module decode_regfile
    import decode_pipe_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [4:0]      rd_addr1,
    input  logic [4:0]      rd_addr2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2
);
    localparam int         AW      = $clog2(NREGS);
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];
    logic            wr_ok;
    logic            rd1_ok;
    logic            rd2_ok;

    assign wr_ok  = wr_en && (wr_addr != 5'd0) && ({1'b0, wr_addr} < NREGS_W);
    assign rd1_ok = (rd_addr1 != 5'd0) && ({1'b0, rd_addr1} < NREGS_W);
    assign rd2_ok = (rd_addr2 != 5'd0) && ({1'b0, rd_addr2} < NREGS_W);

    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_addr[AW-1:0]] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Out-of-range indices read as zero; the stage flags them illegal.
    always_comb begin
        rd_data1 = '0;
        if (rd1_ok) begin
            if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr1)) begin
                rd_data1 = wr_data;
            end else begin
                rd_data1 = mem_q[rd_addr1[AW-1:0]];
            end
        end
    end

    always_comb begin
        rd_data2 = '0;
        if (rd2_ok) begin
            if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr2)) begin
                rd_data2 = wr_data;
            end else begin
                rd_data2 = mem_q[rd_addr2[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/decode_pipe_stage.sv
// Decode pipeline stage: instruction decode, immediate generation, register
// read, load-use hazard detection and the ID/EX pipeline register.
module decode_pipe_stage
    import decode_pipe_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input logic clk,
    input logic rst,
    decode_pipe_stage_if.slave bus
);
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    logic [31:0]     instr;
    logic [4:0]      rd_f;
    logic [4:0]      rs1_f;
    logic [4:0]      rs2_f;
    dec_t            dec;
    logic [XLEN-1:0] imm;
    logic            range_bad;
    logic            illegal;
    logic            hazard;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rd1_q, rd1_d;
    logic [XLEN-1:0] rd2_q, rd2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            i30_q, i30_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic            illegal_q, illegal_d;

    assign instr = bus.if_instr;
    assign rd_f  = instr[11:7];
    assign rs1_f = instr[19:15];
    assign rs2_f = instr[24:20];
    assign dec   = decode_op(instr[6:0]);

    always_comb begin
        imm = '0;
        case (dec.imm_sel)
            IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            default: imm = '0;
        endcase
    end

    // Only register fields the opcode actually uses can make it illegal.
    assign range_bad = (dec.use_rs1        && ({1'b0, rs1_f} >= NREGS_W)) ||
                       (dec.use_rs2        && ({1'b0, rs2_f} >= NREGS_W)) ||
                       (dec.ctrl.reg_write && ({1'b0, rd_f}  >= NREGS_W));
    assign illegal   = !dec.legal || range_bad;

    assign hazard = ex_valid_q && ctrl_q.mem_read && (rd_q != 5'd0) && bus.if_valid &&
                    ((dec.use_rs1 && (rd_q == rs1_f)) || (dec.use_rs2 && (rd_q == rs2_f)));

    assign bus.id_ready = bus.ex_ready && (bus.flush || !hazard);

    decode_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .BYPASS(BYPASS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wb_regWrite),
        .wr_addr (bus.wb_rd),
        .wr_data (bus.wb_writeData),
        .rd_addr1(rs1_f),
        .rd_addr2(rs2_f),
        .rd_data1(rf_rd1),
        .rd_data2(rf_rd2)
    );

    // Bubbles keep the last operands but never carry control bits.
    always_comb begin
        ex_valid_d = ex_valid_q;
        pc_d       = pc_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        funct3_d   = funct3_q;
        i30_d      = i30_q;
        ctrl_d     = ctrl_q;
        illegal_d  = illegal_q;
        if (bus.ex_ready) begin
            if (bus.flush || hazard || !bus.if_valid) begin
                ex_valid_d = 1'b0;
                ctrl_d     = '0;
            end else begin
                ex_valid_d = 1'b1;
                pc_d       = bus.if_pc;
                rd1_d      = rf_rd1;
                rd2_d      = rf_rd2;
                imm_d      = imm;
                rd_d       = rd_f;
                rs1_d      = rs1_f;
                rs2_d      = rs2_f;
                funct3_d   = instr[14:12];
                i30_d      = instr[30];
                ctrl_d     = dec.ctrl;
                illegal_d  = illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            pc_q       <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            funct3_q   <= '0;
            i30_q      <= 1'b0;
            ctrl_q     <= '0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            pc_q       <= pc_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            funct3_q   <= funct3_d;
            i30_q      <= i30_d;
            ctrl_q     <= ctrl_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_pc        = pc_q;
    assign bus.ex_readData1 = rd1_q;
    assign bus.ex_readData2 = rd2_q;
    assign bus.ex_imm       = imm_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_rs1       = rs1_q;
    assign bus.ex_rs2       = rs2_q;
    assign bus.ex_funct3    = funct3_q;
    assign bus.ex_i30       = i30_q;
    assign bus.ex_ctrl      = ctrl_q;
    assign bus.ex_illegal   = illegal_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage: default, BYPASS=0 and NREGS=16
// instances share one stimulus stream.
module tb_decode_pipe_stage;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    decode_pipe_stage_if #(.XLEN(32)) ifa ();
    decode_pipe_stage_if #(.XLEN(32)) ifb ();
    decode_pipe_stage_if #(.XLEN(32)) ifc ();

    decode_pipe_stage dut_a (.clk(clk), .rst(rst), .bus(ifa));
    decode_pipe_stage #(.BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    decode_pipe_stage #(.NREGS(16)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    assign ifb.if_valid = ifa.if_valid;        assign ifc.if_valid = ifa.if_valid;
    assign ifb.if_instr = ifa.if_instr;        assign ifc.if_instr = ifa.if_instr;
    assign ifb.if_pc = ifa.if_pc;              assign ifc.if_pc = ifa.if_pc;
    assign ifb.ex_ready = ifa.ex_ready;        assign ifc.ex_ready = ifa.ex_ready;
    assign ifb.flush = ifa.flush;              assign ifc.flush = ifa.flush;
    assign ifb.wb_regWrite = ifa.wb_regWrite;  assign ifc.wb_regWrite = ifa.wb_regWrite;
    assign ifb.wb_rd = ifa.wb_rd;              assign ifc.wb_rd = ifa.wb_rd;
    assign ifb.wb_writeData = ifa.wb_writeData;
    assign ifc.wb_writeData = ifa.wb_writeData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  ctrl;
        logic [31:0] imm;
        logic        ill;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        i30;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
            input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] op);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        ifa.wb_regWrite  = 1'b1;
        ifa.wb_rd        = rd;
        ifa.wb_writeData = data;
        step();
        ifa.wb_regWrite  = 1'b0;
    endtask

    // Present a load into x7 (or x0), then a follower; check the stall decision.
    task automatic load_then(input string name, input logic [4:0] ld_rd, input logic [31:0] nxt,
            input logic fl, input logic exp_rdy, input logic exp_valid);
        ifa.if_valid = 1'b1;
        ifa.if_instr = enc_i(12'h000, 5'd1, 3'd2, ld_rd, 7'b0000011);
        step();
        ifa.if_instr = nxt;
        ifa.flush    = fl;
        #1;
        chk({name, " id_ready"}, 64'(ifa.id_ready), 64'(exp_rdy));
        step();
        chk({name, " ex_valid"}, 64'(ifa.ex_valid), 64'(exp_valid));
        ifa.flush    = 1'b0;
        ifa.if_valid = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h100, 8'h81, 32'h0,        1'b0, 32'h11, 32'h22, 5'd3,  3'd0, 1'b0};
        vecs[1]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33), 32'h104, 8'h81, 32'h0,        1'b0, 32'h11, 32'h22, 5'd4,  3'd0, 1'b1};
        vecs[2]  = '{enc_i(12'hFFF, 5'd1, 3'd0, 5'd5, 7'h13),     32'h108, 8'hA1, 32'hFFFFFFFF, 1'b0, 32'h11, 32'h0,  5'd5,  3'd0, 1'b1};
        vecs[3]  = '{enc_i(12'h7FF, 5'd2, 3'd7, 5'd9, 7'h13),     32'h10C, 8'hA1, 32'h7FF,      1'b0, 32'h22, 32'h0,  5'd9,  3'd7, 1'b1};
        vecs[4]  = '{enc_i(12'h008, 5'd2, 3'd2, 5'd7, 7'h03),     32'h110, 8'h2D, 32'h8,        1'b0, 32'h22, 32'h0,  5'd7,  3'd2, 1'b0};
        vecs[5]  = '{enc_s(12'hFF8, 5'd1, 5'd2, 3'd2, 7'h23),     32'h114, 8'h22, 32'hFFFFFFF8, 1'b0, 32'h22, 32'h11, 5'd24, 3'd2, 1'b1};
        vecs[6]  = '{enc_b(13'h1FFC, 5'd2, 5'd1, 3'd0, 7'h63),    32'h118, 8'h50, 32'hFFFFFFFC, 1'b0, 32'h11, 32'h22, 5'd29, 3'd0, 1'b1};
        vecs[7]  = '{enc_b(13'h0800, 5'd1, 5'd2, 3'd1, 7'h63),    32'h11C, 8'h50, 32'h800,      1'b0, 32'h22, 32'h11, 5'd1,  3'd1, 1'b0};
        vecs[8]  = '{enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd3, 7'h7F), 32'h120, 8'h00, 32'h0,        1'b1, 32'h0,  32'h0,  5'd3,  3'd0, 1'b0};
        vecs[9]  = '{enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd9, 7'h37), 32'h124, 8'h00, 32'h0,        1'b1, 32'h0,  32'h0,  5'd9,  3'd0, 1'b0};
        vecs[10] = '{enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd3, 7'h33), 32'h128, 8'h81, 32'h0,        1'b0, 32'h0,  32'h0,  5'd3,  3'd0, 1'b0};

        rst              = 1'b0;
        ifa.if_valid     = 1'b0;
        ifa.if_instr     = '0;
        ifa.if_pc        = '0;
        ifa.ex_ready     = 1'b1;
        ifa.flush        = 1'b0;
        ifa.wb_regWrite  = 1'b0;
        ifa.wb_rd        = '0;
        ifa.wb_writeData = '0;
        #12;
        chk("reset ex_valid", 64'(ifa.ex_valid), 64'd0);
        chk("reset ex_ctrl", 64'(ifa.ex_ctrl), 64'd0);
        chk("reset ex_illegal", 64'(ifa.ex_illegal), 64'd0);
        chk("reset ex_pc", 64'(ifa.ex_pc), 64'd0);
        chk("reset ex_imm", 64'(ifa.ex_imm), 64'd0);
        step();
        rst = 1'b1;

        // Asynchronous reset in the middle of a cycle, with a valid bundle held.
        wb_write(5'd1, 32'h55);
        ifa.if_valid = 1'b1;
        ifa.if_instr = enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd3, 7'h33);
        ifa.if_pc    = 32'h40;
        step();
        chk("pre-reset ex_valid", 64'(ifa.ex_valid), 64'd1);
        chk("pre-reset readData1", 64'(ifa.ex_readData1), 64'h55);
        #3;
        rst = 1'b0;
        #1;
        chk("async reset ex_valid", 64'(ifa.ex_valid), 64'd0);
        chk("async reset ex_ctrl", 64'(ifa.ex_ctrl), 64'd0);
        chk("async reset readData1", 64'(ifa.ex_readData1), 64'd0);
        chk("async reset ex_pc", 64'(ifa.ex_pc), 64'd0);
        #2;
        rst = 1'b1;
        step();
        chk("post-release ex_valid", 64'(ifa.ex_valid), 64'd1);
        chk("post-release x1 reads 0", 64'(ifa.ex_readData1), 64'd0);

        ifa.if_valid = 1'b0;
        wb_write(5'd1, 32'h11);
        wb_write(5'd2, 32'h22);
        wb_write(5'd0, 32'hDEAD);

        for (int i = 0; i < 11; i++) begin
            ifa.if_valid = 1'b1;
            ifa.if_instr = vecs[i].instr;
            ifa.if_pc    = vecs[i].pc;
            step();
            chk($sformatf("vec%0d ex_valid", i), 64'(ifa.ex_valid), 64'd1);
            chk($sformatf("vec%0d ex_ctrl", i), 64'(ifa.ex_ctrl), 64'(vecs[i].ctrl));
            chk($sformatf("vec%0d ex_imm", i), 64'(ifa.ex_imm), 64'(vecs[i].imm));
            chk($sformatf("vec%0d ex_illegal", i), 64'(ifa.ex_illegal), 64'(vecs[i].ill));
            chk($sformatf("vec%0d readData1", i), 64'(ifa.ex_readData1), 64'(vecs[i].rd1));
            chk($sformatf("vec%0d readData2", i), 64'(ifa.ex_readData2), 64'(vecs[i].rd2));
            chk($sformatf("vec%0d rd/f3/i30", i), 64'({ifa.ex_rd, ifa.ex_funct3, ifa.ex_i30}),
                64'({vecs[i].rd, vecs[i].f3, vecs[i].i30}));
            chk($sformatf("vec%0d ex_pc", i), 64'(ifa.ex_pc), 64'(vecs[i].pc));
            ifa.if_valid = 1'b0;
            step();
            chk($sformatf("vec%0d bubble ex_valid", i), 64'(ifa.ex_valid), 64'd0);
            chk($sformatf("vec%0d bubble ex_ctrl", i), 64'(ifa.ex_ctrl), 64'd0);
            chk($sformatf("vec%0d bubble ex_imm held", i), 64'(ifa.ex_imm), 64'(vecs[i].imm));
        end

        // Same-cycle writeback and read of x5.
        ifa.wb_regWrite  = 1'b1;
        ifa.wb_rd        = 5'd5;
        ifa.wb_writeData = 32'h1234;
        ifa.if_valid     = 1'b1;
        ifa.if_instr     = enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd6, 7'h33);
        step();
        ifa.wb_regWrite  = 1'b0;
        chk("bypass1 readData1", 64'(ifa.ex_readData1), 64'h1234);
        chk("bypass0 readData1", 64'(ifb.ex_readData1), 64'h0);
        step();
        chk("bypass0 after write", 64'(ifb.ex_readData1), 64'h1234);
        chk("bypass1 after write", 64'(ifa.ex_readData1), 64'h1234);
        ifa.if_valid = 1'b0;
        step();

        // lw x7,0(x1) followed by add x8,x7,x2: exactly one bubble.
        ifa.if_valid = 1'b1;
        ifa.if_instr = enc_i(12'h000, 5'd1, 3'd2, 5'd7, 7'h03);
        step();
        chk("load-use lw ctrl", 64'(ifa.ex_ctrl), 64'h2D);
        ifa.if_instr = enc_r(7'h00, 5'd2, 5'd7, 3'd0, 5'd8, 7'h33);
        #1;
        chk("load-use id_ready stall", 64'(ifa.id_ready), 64'd0);
        step();
        chk("load-use bubble ex_valid", 64'(ifa.ex_valid), 64'd0);
        chk("load-use bubble ex_ctrl", 64'(ifa.ex_ctrl), 64'd0);
        chk("load-use id_ready resolved", 64'(ifa.id_ready), 64'd1);
        step();
        chk("load-use add ex_valid", 64'(ifa.ex_valid), 64'd1);
        chk("load-use add ex_rd", 64'(ifa.ex_rd), 64'd8);
        chk("load-use add ex_ctrl", 64'(ifa.ex_ctrl), 64'h81);
        ifa.if_valid = 1'b0;
        step();

        load_then("hazard rs2 store", 5'd7, enc_s(12'h000, 5'd7, 5'd2, 3'd2, 7'h23), 1'b0, 1'b0, 1'b0);
        load_then("no dependency", 5'd7, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd8, 7'h33), 1'b0, 1'b1, 1'b1);
        load_then("load to x0", 5'd0, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd8, 7'h33), 1'b0, 1'b1, 1'b1);
        load_then("flush over hazard", 5'd7, enc_r(7'h00, 5'd2, 5'd7, 3'd0, 5'd8, 7'h33), 1'b1, 1'b1, 1'b0);
        load_then("imm field not rs2", 5'd7, enc_i(12'h007, 5'd1, 3'd0, 5'd8, 7'h13), 1'b0, 1'b1, 1'b1);

        // Downstream stall for three cycles; flush while stalled is ignored.
        ifa.if_valid = 1'b1;
        ifa.if_instr = vecs[1].instr;
        ifa.if_pc    = 32'h200;
        step();
        ifa.ex_ready = 1'b0;
        ifa.if_instr = vecs[0].instr;
        ifa.if_pc    = 32'h204;
        for (int k = 0; k < 3; k++) begin
            ifa.flush = (k == 1);
            #1;
            chk($sformatf("stall%0d id_ready", k), 64'(ifa.id_ready), 64'd0);
            step();
            chk($sformatf("stall%0d ex_valid", k), 64'(ifa.ex_valid), 64'd1);
            chk($sformatf("stall%0d ex_rd/i30", k), 64'({ifa.ex_rd, ifa.ex_i30}), 64'({5'd4, 1'b1}));
            chk($sformatf("stall%0d ex_pc", k), 64'(ifa.ex_pc), 64'h200);
            chk($sformatf("stall%0d ex_ctrl", k), 64'(ifa.ex_ctrl), 64'h81);
        end
        ifa.flush    = 1'b0;
        ifa.ex_ready = 1'b1;
        step();
        chk("stall release ex_rd", 64'(ifa.ex_rd), 64'd3);
        chk("stall release ex_pc", 64'(ifa.ex_pc), 64'h204);

        // Taken-branch flush of the instruction being decoded.
        ifa.flush = 1'b1;
        ifa.if_pc = 32'h208;
        #1;
        chk("flush id_ready", 64'(ifa.id_ready), 64'd1);
        step();
        chk("flush ex_valid", 64'(ifa.ex_valid), 64'd0);
        chk("flush ex_ctrl", 64'(ifa.ex_ctrl), 64'd0);
        ifa.flush = 1'b0;

        // Register index range on the 16-register instance.
        ifa.if_instr = enc_r(7'h00, 5'd0, 5'd20, 3'd0, 5'd3, 7'h33);
        step();
        chk("nregs16 rs1=x20 illegal", 64'(ifc.ex_illegal), 64'd1);
        chk("nregs16 rs1=x20 ex_valid", 64'(ifc.ex_valid), 64'd1);
        chk("nregs32 rs1=x20 legal", 64'(ifa.ex_illegal), 64'd0);
        ifa.if_instr = enc_r(7'h00, 5'd0, 5'd15, 3'd0, 5'd3, 7'h33);
        step();
        chk("nregs16 rs1=x15 legal", 64'(ifc.ex_illegal), 64'd0);
        ifa.if_instr = enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd20, 7'h33);
        step();
        chk("nregs16 rd=x20 illegal", 64'(ifc.ex_illegal), 64'd1);
        ifa.if_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
